// File: rtl/tetris_pkg.sv
// Shared piece ids, move encodings, FSM state type and the tetromino shape-offset ROM.
package tetris_pkg;

  localparam logic [2:0] PieceNone = 3'd0;
  localparam logic [2:0] PieceI    = 3'd1;
  localparam logic [2:0] PieceO    = 3'd2;
  localparam logic [2:0] PieceT    = 3'd3;
  localparam logic [2:0] PieceS    = 3'd4;
  localparam logic [2:0] PieceZ    = 3'd5;
  localparam logic [2:0] PieceJ    = 3'd6;
  localparam logic [2:0] PieceL    = 3'd7;

  typedef enum logic [1:0] {
    DirDown  = 2'b00,
    DirLeft  = 2'b01,
    DirRight = 2'b10,
    DirRot   = 2'b11
  } dir_e;

  typedef enum logic [1:0] {StIdle, StAddr, StSample, StDone} state_e;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } cell_off_t;

  // Offsets are for rotation 0 with +y pointing up; each clockwise step maps (dx,dy) -> (dy,-dx).
  function automatic cell_off_t shape_offset(input logic [2:0] id, input logic [1:0] rot,
                                             input logic [1:0] k);
    int dxs[4];
    int dys[4];
    logic signed [2:0] bx, by, t;
    cell_off_t off;
    case (id)
      PieceI:  begin dxs = '{-1, 0, 1, 2}; dys = '{0, 0, 0, 0}; end
      PieceO:  begin dxs = '{0, 1, 0, 1};  dys = '{0, 0, 1, 1}; end
      PieceT:  begin dxs = '{-1, 0, 1, 0}; dys = '{0, 0, 0, 1}; end
      PieceS:  begin dxs = '{-1, 0, 0, 1}; dys = '{0, 0, 1, 1}; end
      PieceZ:  begin dxs = '{-1, 0, 0, 1}; dys = '{1, 1, 0, 0}; end
      PieceJ:  begin dxs = '{-1, -1, 0, 1}; dys = '{1, 0, 0, 0}; end
      PieceL:  begin dxs = '{-1, 0, 1, 1}; dys = '{0, 0, 0, 1}; end
      default: begin dxs = '{0, 0, 0, 0};  dys = '{0, 0, 0, 0}; end
    endcase
    bx = 3'(dxs[k]);
    by = 3'(dys[k]);
    // The O piece is rotation-invariant; rotating it about its corner would shift it.
    if (id != PieceO) begin
      for (int r = 0; r < 3; r++) begin
        if (r < int'(rot)) begin
          t  = bx;
          bx = by;
          by = -t;
        end
      end
    end
    off.dx = bx;
    off.dy = by;
    return off;
  endfunction

endpackage

// File: rtl/piece_collision_if.sv
// Request/result and board-RAM read signals of piece_collision; the master side owns the board.
interface piece_collision_if #(
  parameter int unsigned COORD_W = 5
) ();
  logic               Start;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [2:0]         id;
  logic [1:0]         rot;
  logic [1:0]         dir;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [2:0]         in_id;
  logic               Ready;
  logic               Done;
  logic               blocked;
  logic               place;

  modport master (
    output Start, x, y, id, rot, dir, in_id,
    input  pos_x, pos_y, Ready, Done, blocked, place
  );

  modport slave (
    input  Start, x, y, id, rot, dir, in_id,
    output pos_x, pos_y, Ready, Done, blocked, place
  );
endinterface

// File: rtl/piece_cells.sv
// Combinational footprint: piece id, rotation and anchor to four signed board coordinates.
module piece_cells
  import tetris_pkg::*;
#(
  parameter int unsigned COORD_W = 5
) (
  input  logic [2:0]                id,
  input  logic [1:0]                rot,
  input  logic signed [COORD_W:0]   anchor_x,
  input  logic signed [COORD_W:0]   anchor_y,
  output logic signed [COORD_W:0]   cell_x [4],
  output logic signed [COORD_W:0]   cell_y [4]
);

  for (genvar i = 0; i < 4; i++) begin : g_cell
    cell_off_t off;
    assign off       = shape_offset(id, rot, 2'(i));
    assign cell_x[i] = anchor_x + $signed({{(COORD_W - 2){off.dx[2]}}, off.dx});
    assign cell_y[i] = anchor_y + $signed({{(COORD_W - 2){off.dy[2]}}, off.dy});
  end

endmodule

// File: rtl/piece_collision.sv
// Tests one tetromino move against the board, one RAM read per in-board cell, early exit on hit.
// Define PIECE_SELF_MASK_EN to ignore board cells that belong to the piece's pre-move footprint.
module piece_collision
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20,
  parameter int unsigned COORD_W = 5
) (
  input  logic              clk,
  input  logic              Reset_n,
  piece_collision_if.slave  bus
);

  localparam logic signed [COORD_W:0] BoardW = (COORD_W + 1)'(BOARD_W);
  localparam logic signed [COORD_W:0] BoardH = (COORD_W + 1)'(BOARD_H);
  localparam logic signed [COORD_W:0] One    = (COORD_W + 1)'(1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, y_q;
  logic [2:0]         id_q;
  logic [1:0]         rot_q;
  dir_e               dir_q;
  logic [1:0]         k_q, k_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic               blocked_q, blocked_d, place_q, place_d;
  logic               capture, finish, hit;

  logic signed [COORD_W:0] cand_ax, cand_ay;
  logic [1:0]              cand_rot;
  logic signed [COORD_W:0] cand_x [4];
  logic signed [COORD_W:0] cand_y [4];
  logic signed [COORD_W:0] cur_x, cur_y;
  logic                    out_of_board, above_board, self_hit, occupied;

  always_comb begin
    cand_ax  = $signed({1'b0, x_q});
    cand_ay  = $signed({1'b0, y_q});
    cand_rot = rot_q;
    unique case (dir_q)
      DirDown:  cand_ay  = $signed({1'b0, y_q}) - One;
      DirLeft:  cand_ax  = $signed({1'b0, x_q}) - One;
      DirRight: cand_ax  = $signed({1'b0, x_q}) + One;
      DirRot:   cand_rot = rot_q + 2'd1;
      default:  ;
    endcase
  end

  piece_cells #(
    .COORD_W (COORD_W)
  ) u_cand (
    .id       (id_q),
    .rot      (cand_rot),
    .anchor_x (cand_ax),
    .anchor_y (cand_ay),
    .cell_x   (cand_x),
    .cell_y   (cand_y)
  );

  assign cur_x        = cand_x[k_q];
  assign cur_y        = cand_y[k_q];
  assign out_of_board = cur_x[COORD_W] || (cur_x >= BoardW) || cur_y[COORD_W];
  assign above_board  = cur_y >= BoardH;

`ifdef PIECE_SELF_MASK_EN
  logic signed [COORD_W:0] prev_x [4];
  logic signed [COORD_W:0] prev_y [4];

  piece_cells #(
    .COORD_W (COORD_W)
  ) u_prev (
    .id       (id_q),
    .rot      (rot_q),
    .anchor_x ($signed({1'b0, x_q})),
    .anchor_y ($signed({1'b0, y_q})),
    .cell_x   (prev_x),
    .cell_y   (prev_y)
  );

  always_comb begin
    self_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (prev_x[i] == $signed({1'b0, pos_x_q}) && prev_y[i] == $signed({1'b0, pos_y_q})) begin
        self_hit = 1'b1;
      end
    end
  end
`else
  assign self_hit = 1'b0;
`endif

  assign occupied = (bus.in_id != 3'd0) && !self_hit;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    capture = 1'b0;
    finish  = 1'b0;
    hit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          capture = 1'b1;
          k_d     = 2'd0;
          if (bus.id == PieceNone) begin
            finish  = 1'b1;
            hit     = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (out_of_board) begin
          finish  = 1'b1;
          hit     = 1'b1;
          state_d = StDone;
        end else if (above_board) begin
          // Cells above the visible board never collide and need no read.
          if (k_q == 2'd3) begin
            finish  = 1'b1;
            state_d = StDone;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else begin
          pos_x_d = cur_x[COORD_W-1:0];
          pos_y_d = cur_y[COORD_W-1:0];
          state_d = StSample;
        end
      end
      StSample: begin
        if (occupied) begin
          finish  = 1'b1;
          hit     = 1'b1;
          state_d = StDone;
        end else if (k_q == 2'd3) begin
          finish  = 1'b1;
          state_d = StDone;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = StAddr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    blocked_d = finish ? hit : blocked_q;
    place_d   = finish ? (hit && !capture && dir_q == DirDown) : place_q;
  end

  always_comb begin
    bus.Ready   = (state_q == StIdle);
    bus.Done    = (state_q == StDone);
    bus.blocked = blocked_q;
    bus.place   = place_q;
    bus.pos_x   = pos_x_q;
    bus.pos_y   = pos_y_q;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      id_q      <= PieceNone;
      rot_q     <= 2'd0;
      dir_q     <= DirDown;
      k_q       <= 2'd0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      blocked_q <= 1'b0;
      place_q   <= 1'b0;
    end else begin
      if (capture) begin
        x_q   <= bus.x;
        y_q   <= bus.y;
        id_q  <= bus.id;
        rot_q <= bus.rot;
        dir_q <= dir_e'(bus.dir);
      end
      k_q       <= k_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      blocked_q <= blocked_d;
      place_q   <= place_d;
    end
  end

endmodule

// File: tb/tb_piece_collision.sv
// Directed bench for piece_collision with a combinational board model behind pos_x/pos_y.
module tb_piece_collision;
  import tetris_pkg::*;

  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;

  piece_collision_if #(.COORD_W(CW)) bus_if ();

  piece_collision #(
    .BOARD_W (10),
    .BOARD_H (20),
    .COORD_W (CW)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  logic [2:0] board [32][32];
  always_comb bus_if.in_id = board[bus_if.pos_x][bus_if.pos_y];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        board[i][j] = 3'd0;
      end
    end
  endtask

  // Issues one request, scrambles inputs after capture, pokes Start mid-scan, checks the result.
  task automatic run(input string tag, input logic [2:0] id_v, input logic [1:0] rot_v,
                     input logic [1:0] dir_v, input int x_v, input int y_v,
                     input int exp_cyc, input int exp_blk, input int exp_plc);
    int cyc;
    @(negedge clk);
    bus_if.id    = id_v;
    bus_if.rot   = rot_v;
    bus_if.dir   = dir_v;
    bus_if.x     = CW'(x_v);
    bus_if.y     = CW'(y_v);
    bus_if.Start = 1'b1;
    @(negedge clk);
    bus_if.Start = 1'b0;
    bus_if.x     = 5'd31;
    bus_if.y     = 5'd31;
    bus_if.id    = 3'd7;
    bus_if.rot   = 2'd2;
    bus_if.dir   = DirLeft;
    cyc = 1;
    check({tag, ".busy"}, int'(bus_if.Ready), 0);
    while (!bus_if.Done && cyc < 20) begin
      bus_if.Start = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    bus_if.Start = 1'b0;
    check({tag, ".done_seen"}, int'(bus_if.Done), 1);
    check({tag, ".latency"}, cyc, exp_cyc);
    check({tag, ".blocked"}, int'(bus_if.blocked), exp_blk);
    check({tag, ".place"}, int'(bus_if.place), exp_plc);
    @(negedge clk);
    check({tag, ".done_pulse"}, int'(bus_if.Done), 0);
    check({tag, ".ready"}, int'(bus_if.Ready), 1);
  endtask

  task automatic check_pos(input string tag, input int px, input int py);
    check({tag, ".pos_x"}, int'(bus_if.pos_x), px);
    check({tag, ".pos_y"}, int'(bus_if.pos_y), py);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bus_if.Start = 1'b0;
    bus_if.x     = '0;
    bus_if.y     = '0;
    bus_if.id    = PieceNone;
    bus_if.rot   = 2'd0;
    bus_if.dir   = DirDown;
    clear_board();

    #12;
    check("reset.ready", int'(bus_if.Ready), 1);
    check("reset.done", int'(bus_if.Done), 0);
    check("reset.blocked", int'(bus_if.blocked), 0);
    check("reset.place", int'(bus_if.place), 0);
    check_pos("reset", 0, 0);
    @(negedge clk);
    Reset_n = 1'b1;

    run("down_free", PieceI, 2'd0, DirDown, 4, 10, 9, 0, 0);
    check_pos("down_free", 6, 9);
    run("floor", PieceI, 2'd0, DirDown, 4, 0, 2, 1, 1);
    check_pos("floor", 6, 9);
    run("left_wall", PieceO, 2'd0, DirLeft, 0, 10, 2, 1, 0);
    run("right_wall", PieceO, 2'd0, DirRight, 8, 10, 4, 1, 0);
    check_pos("right_wall", 9, 10);

    board[4][4] = 3'd3;
    run("early_exit", PieceI, 2'd0, DirDown, 4, 5, 5, 1, 1);
    check_pos("early_exit", 4, 4);
    clear_board();

    // Asynchronous reset while the second state of a scan (SAMPLE) is active.
    @(negedge clk);
    bus_if.id    = PieceI;
    bus_if.rot   = 2'd0;
    bus_if.dir   = DirDown;
    bus_if.x     = 5'd4;
    bus_if.y     = 5'd10;
    bus_if.Start = 1'b1;
    @(negedge clk);
    bus_if.Start = 1'b0;
    @(negedge clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check("midreset.ready", int'(bus_if.Ready), 1);
    check("midreset.done", int'(bus_if.Done), 0);
    check("midreset.blocked", int'(bus_if.blocked), 0);
    check("midreset.place", int'(bus_if.place), 0);
    check_pos("midreset", 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset.no_done", int'(bus_if.Done), 0);
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postreset.no_done", int'(bus_if.Done), 0);
      check("postreset.ready", int'(bus_if.Ready), 1);
    end
    run("fresh", PieceI, 2'd0, DirDown, 4, 10, 9, 0, 0);

    run("id_zero", PieceNone, 2'd0, DirDown, 4, 10, 1, 1, 0);
    run("rot_wall", PieceI, 2'd1, DirRot, 0, 10, 6, 1, 0);
    check_pos("rot_wall", 0, 10);

    board[6][10] = 3'd5;
    run("rot_wrap", PieceI, 2'd3, DirRot, 4, 10, 9, 1, 0);
    check_pos("rot_wrap", 6, 10);
    clear_board();

    run("ceiling", PieceI, 2'd3, DirDown, 4, 20, 7, 0, 0);
    check_pos("ceiling", 4, 19);

    for (int i = 2; i <= 5; i++) board[i][15] = PieceI;
`ifdef PIECE_SELF_MASK_EN
    run("self_mask", PieceI, 2'd0, DirRight, 3, 15, 9, 0, 0);
    check_pos("self_mask", 6, 15);
`else
    run("self_hit", PieceI, 2'd0, DirRight, 3, 15, 3, 1, 0);
    check_pos("self_hit", 3, 15);
`endif
    clear_board();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_collision.md
PIECE_COLLISION -- requirements
Module: piece_collision

Interface
REQ-001 SHALL have parameter BOARD_W, 10, board columns.
REQ-002 SHALL have parameter BOARD_H, 20, board rows; row 0 is the floor.
REQ-003 SHALL have parameter COORD_W, 5, coordinate width; must satisfy 2^COORD_W >= max(BOARD_W, BOARD_H+4).
REQ-004 SHALL have port clk input 1 clock; the block uses this one clock only, rising edge.
REQ-005 SHALL have port Reset_n input 1 reset; it is asynchronous and active-low.
REQ-006 SHALL have port Start input 1 check request; sampled only while Ready=1.
REQ-007 SHALL have ports x, y input COORD_W each: current piece anchor.
REQ-008 SHALL have port id input 3: piece type, 1..7 valid.
REQ-009 SHALL have port rot input 2: current rotation.
REQ-010 SHALL have port dir input 2: move to test; 00 down, 01 left, 10 right, 11 rotate clockwise.
REQ-011 SHALL have ports pos_x, pos_y output COORD_W each: board RAM read address.
REQ-012 SHALL have port in_id input 3: board cell content at pos_x/pos_y; 0 means empty; valid one cycle after the address.
REQ-013 SHALL have port Ready output 1: idle and able to accept Start.
REQ-014 SHALL have port Done output 1: one-cycle pulse when the result is valid.
REQ-015 SHALL have port blocked output 1: the tested move collides; held until the next Start.
REQ-016 SHALL have port place output 1: blocked with dir=00; lock the piece; held with blocked.

Function
REQ-017 SHALL use FSM states IDLE, ADDR, SAMPLE, DONE; Ready=1 only in IDLE.
REQ-018 SHALL, on Start in IDLE, register x, y, id, rot, dir, set cell index k=0, and enter ADDR.
REQ-019 SHALL compute the candidate anchor as follows: down y-1; left x-1; right x+1; rotate (rot+1) mod 4.
REQ-020 SHALL take cell k offsets from a shape ROM indexed by id, rotation, and k, and add them to the anchor in signed COORD_W+1 arithmetic.
REQ-021 SHALL, in ADDR, treat a cell as blocked with no RAM read if its column <0 or >=BOARD_W, or its row <0; then go to DONE.
REQ-022 SHALL treat a cell with row >=BOARD_H as empty; go to k+1, or to DONE after k=3.
REQ-023 SHALL otherwise drive the in-range cell on pos_x/pos_y (registered) and go to SAMPLE.
REQ-024 SHALL, in SAMPLE, treat in_id!=0 as blocked and go to DONE (early exit); otherwise go to ADDR with k+1, or to DONE after k=3.
REQ-025 SHALL pulse Done for one cycle in DONE, update blocked and place, and return to IDLE.
REQ-026 SHALL have latency from Start to Done of at most 9 cycles (4 cells x 2, plus DONE), and SHALL scan in fixed order k=0..3.
REQ-027 SHALL, for id=0, go straight to DONE with blocked=1, place=0.
REQ-028 SHALL ignore Start outside IDLE; inputs may change freely after capture.
REQ-029 SHALL hold pos_x/pos_y at their last value when not in ADDR.

Reset
REQ-030 SHALL, on Reset_n low (asynchronous, any state including mid-scan), enter IDLE and set Ready=1, Done=0, blocked=0, place=0, pos_x=0, pos_y=0, k=0.
REQ-031 SHALL sample Start no earlier than the first rising clk edge after Reset_n deasserts.

Configuration
REQ-032 SHALL, with PIECE_SELF_MASK_EN defined, treat a non-empty cell as empty if it equals any of the piece's four pre-move cells, so a board that already holds the active piece does not self-collide.
REQ-033 SHALL, without PIECE_SELF_MASK_EN, treat every non-zero in_id as a collision; no mask logic is built.

Structure
REQ-034 SHALL place the shape-offset ROM function, piece id constants, dir encodings, and FSM state typedef in package tetris_pkg.
REQ-035 SHALL use one sub-module, piece_cells: combinational id/rot/anchor to four signed cell coordinates; it is used for the candidate and, with the mask, for the pre-move footprint.

Verification
REQ-036 SHALL cover: id=1 (I), x=4, y=10, dir=down, all in_id=0 -> Done within 9 cycles, blocked=0, place=0.
REQ-037 SHALL cover: id=1, y=0, dir=down -> blocked=1, place=1, no RAM read issued.
REQ-038 SHALL cover: x=0, dir=left -> blocked=1, place=0; x at right edge, dir=right -> blocked=1.
REQ-039 SHALL cover: y=5, dir=down, in_id=3 at the second cell -> Done 5 cycles after Start (early exit), blocked=1, place=1.
REQ-040 SHALL cover: Reset_n low during SAMPLE -> immediate IDLE, Ready=1, no Done pulse; a fresh Start then completes normally.
REQ-041 SHALL cover: with PIECE_SELF_MASK_EN, the board holds the piece's own cells, dir=right into free space -> blocked=0.
